// File: rtl/pe_pkg.sv
// Shared definitions for the 3x3 processing-element MAC array.
//   load_state_e : kernel load FSM states (ROW0..ROW2 accept weight rows, LOADED computes)
//   acc_width()  : accumulator width for the sum of nine 2*DATA_WIDTH products
//   tap_row/col  : tap index k (0..8) to kernel row k/3 and column k%3
package pe_pkg;

  typedef enum logic [1:0] {
    ROW0   = 2'd0,
    ROW1   = 2'd1,
    ROW2   = 2'd2,
    LOADED = 2'd3
  } load_state_e;

  localparam int NUM_ROWS = 3;
  localparam int NUM_COLS = 3;
  localparam int NUM_TAPS = NUM_ROWS * NUM_COLS;

  // Nine products need ceil(log2(9)) = 4 guard bits.
  function automatic int acc_width(input int data_width);
    return 2 * data_width + 4;
  endfunction

  function automatic int tap_row(input int k);
    return k / NUM_COLS;
  endfunction

  function automatic int tap_col(input int k);
    return k % NUM_COLS;
  endfunction

endpackage

// File: rtl/pe_ch_mac.sv
// One channel of the array: 3x3 weight storage, nine multipliers (S1),
// adder tree (S2) and round / ReLU / saturate into the output register (S3).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (output register only)
//   wt_row_we   : one-hot row write enable, bit r writes kernel row r
//   wt_row      : three weights of the row, column 0 in the MSBs
//   adv         : pipeline advance (low while the output is stalled)
//   act_taps    : nine activation taps, tap 0 in the MSBs
//   relu_s3     : ReLU flag of the beat moving from S2 into S3
//   out_data    : requantised channel result
module pe_ch_mac
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_ROWS-1:0]            wt_row_we,
  input  logic [NUM_COLS*DATA_WIDTH-1:0] wt_row,
  input  logic                           adv,
  input  logic [NUM_TAPS*DATA_WIDTH-1:0] act_taps,
  input  logic                           relu_s3,
  output logic [DATA_WIDTH-1:0]          out_data
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int AW = acc_width(DATA_WIDTH);

  localparam logic signed [AW-1:0] RND_HALF = AW'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [AW-1:0] SAT_MAX  = (AW'(1) <<< (DATA_WIDTH - 1)) - AW'(1);
  localparam logic signed [AW-1:0] SAT_MIN  = ~SAT_MAX;

  logic signed [DATA_WIDTH-1:0] w_q    [NUM_ROWS][NUM_COLS];
  logic signed [DATA_WIDTH-1:0] w_d    [NUM_ROWS][NUM_COLS];
  logic signed [PW-1:0]         prod_q [NUM_TAPS];
  logic signed [PW-1:0]         prod_d [NUM_TAPS];
  logic signed [AW-1:0]         sum_q, sum_d;
  logic signed [AW-1:0]         rnd_s, relu_s;
  logic [DATA_WIDTH-1:0]        out_q, out_d;

  always_comb begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        w_d[r][c] = w_q[r][c];
        if (wt_row_we[r]) begin
          w_d[r][c] = wt_row[(NUM_COLS-1-c)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // S1: tap k multiplies the weight at row k/3, column k%3.
  always_comb begin
    for (int k = 0; k < NUM_TAPS; k++) begin
      prod_d[k] = prod_q[k];
      if (adv) begin
        prod_d[k] = $signed(act_taps[(NUM_TAPS-1-k)*DATA_WIDTH +: DATA_WIDTH])
                  * w_q[tap_row(k)][tap_col(k)];
      end
    end
  end

  // S2: sign-extended sum of the nine products.
  always_comb begin
    sum_d = sum_q;
    if (adv) begin
      sum_d = '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        sum_d = sum_d + AW'(prod_q[k]);
      end
    end
  end

  // S3: round half up, drop the fraction, ReLU, then clamp to DATA_WIDTH.
  always_comb begin
    rnd_s  = (sum_q + RND_HALF) >>> FRAC_BITS;
    relu_s = (relu_s3 && (rnd_s < 0)) ? '0 : rnd_s;
    out_d  = out_q;
    if (adv) begin
      if (relu_s > SAT_MAX) begin
        out_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else if (relu_s < SAT_MIN) begin
        out_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
        out_d = relu_s[DATA_WIDTH-1:0];
      end
    end
  end

  // Data registers carry no reset; their validity is tracked by the parent.
  always_ff @(posedge clk) begin
    w_q    <= w_d;
    prod_q <= prod_d;
    sum_q  <= sum_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out_data = out_q;

endmodule

// File: rtl/pe_array_mac.sv
// Array of NUM_CH independent 3x3 MAC channels sharing one kernel-load FSM
// and one 3-stage valid/stall pipeline.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   ker_clear            : request kernel reload (honoured only when LOADED and empty)
//   wt_valid/ready/data  : one kernel row for every channel per beat, channel 0 in MSBs
//   act_valid/ready/data : nine taps per channel per beat, relu_en travels with the beat
//   out_valid/ready/data : one DATA_WIDTH result per channel
//   ker_loaded           : all three kernel rows are held
module pe_array_mac
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 64,
  parameter int FRAC_BITS  = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  ker_clear,
  input  logic                                  wt_valid,
  output logic                                  wt_ready,
  input  logic [NUM_CH*NUM_COLS*DATA_WIDTH-1:0] wt_data,
  input  logic                                  act_valid,
  output logic                                  act_ready,
  input  logic [NUM_CH*NUM_TAPS*DATA_WIDTH-1:0] act_data,
  input  logic                                  relu_en,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0]          out_data,
  output logic                                  ker_loaded
);

  load_state_e         state_q, state_d;
  logic                wt_ready_q, ker_loaded_q;
  logic                v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic                r1_q, r1_d, r2_q, r2_d;
  logic                stall, adv, wt_fire, act_fire, pipe_empty;
  logic [NUM_ROWS-1:0] wt_row_we;

  assign stall      = v3_q && !out_ready;
  assign adv        = !stall;
  assign act_ready  = ker_loaded_q && adv;
  assign wt_fire    = wt_valid && wt_ready_q;
  assign act_fire   = act_valid && act_ready;
  assign pipe_empty = !v1_q && !v2_q && !v3_q;

  assign wt_ready   = wt_ready_q;
  assign ker_loaded = ker_loaded_q;
  assign out_valid  = v3_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ROW0:    if (wt_fire) state_d = ROW1;
      ROW1:    if (wt_fire) state_d = ROW2;
      ROW2:    if (wt_fire) state_d = LOADED;
      LOADED:  if (ker_clear && pipe_empty) state_d = ROW0;
      default: state_d = ROW0;
    endcase
  end

  always_comb begin
    wt_row_we    = '0;
    wt_row_we[0] = wt_fire && (state_q == ROW0);
    wt_row_we[1] = wt_fire && (state_q == ROW1);
    wt_row_we[2] = wt_fire && (state_q == ROW2);
  end

  // Every stage shifts together unless the output is stalled.
  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    v3_d = v3_q;
    r1_d = r1_q;
    r2_d = r2_q;
    if (adv) begin
      v1_d = act_fire;
      v2_d = v1_q;
      v3_d = v2_q;
      r1_d = relu_en;
      r2_d = r1_q;
    end
  end

  // FSM state with its registered outputs, plus the stage-valid flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ROW0;
      wt_ready_q   <= 1'b1;
      ker_loaded_q <= 1'b0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      v3_q         <= 1'b0;
      r1_q         <= 1'b0;
      r2_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      wt_ready_q   <= (state_d != LOADED);
      ker_loaded_q <= (state_d == LOADED);
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      v3_q         <= v3_d;
      r1_q         <= r1_d;
      r2_q         <= r2_d;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    pe_ch_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .wt_row_we (wt_row_we),
      .wt_row    (wt_data[(NUM_CH-1-gi)*NUM_COLS*DATA_WIDTH +: NUM_COLS*DATA_WIDTH]),
      .adv       (adv),
      .act_taps  (act_data[(NUM_CH-1-gi)*NUM_TAPS*DATA_WIDTH +: NUM_TAPS*DATA_WIDTH]),
      .relu_s3   (r2_q),
      .out_data  (out_data[(NUM_CH-1-gi)*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: doc/pe_array_mac.md
PE_ARRAY_MAC -- requirements
Module: pe_array_mac

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, signed two's-complement width of weights, activations and outputs.
REQ-002 SHALL have parameter NUM_CH, default 64, number of independent 3x3 channels.
REQ-003 SHALL have parameter FRAC_BITS, default 8, fixed-point fraction bits removed at requantisation (1..2*DATA_WIDTH-1).
REQ-004 SHALL have ports: clk input 1, the single clock; rst_n input 1, asynchronous active-low reset.
REQ-005 SHALL have ports: ker_clear input 1, pulse requesting kernel reload; wt_valid input 1; wt_ready output 1; wt_data input NUM_CH*3*DATA_WIDTH, one kernel row for every channel.
REQ-006 SHALL have ports: act_valid input 1; act_ready output 1; act_data input NUM_CH*9*DATA_WIDTH, 9 taps per channel; relu_en input 1, sampled with each accepted activation beat.
REQ-007 SHALL have ports: out_valid output 1; out_ready input 1; out_data output NUM_CH*DATA_WIDTH; ker_loaded output 1, high when all three rows are held.
REQ-008 SHALL pack channel 0 in the MSBs of every bus; within a channel, row 0 / tap 0 in the MSBs.

Function
REQ-009 SHALL run a load FSM with states ROW0, ROW1, ROW2, LOADED; ROW0 after reset.
REQ-010 SHALL assert wt_ready in ROW0..ROW2 only; each wt_valid&&wt_ready beat stores row n for all channels and advances ROWn->ROWn+1, ROW2->LOADED.
REQ-011 SHALL drive ker_loaded=1 only in LOADED.
REQ-012 SHALL, in LOADED, return to ROW0 on ker_clear only when all pipeline stages are empty; ker_clear is otherwise ignored (not stored).
REQ-013 SHALL ignore ker_clear in ROW0..ROW2; a beat accepted in the same cycle still advances the FSM.
REQ-014 SHALL map tap k (0..8) to weight row k/3, column k%3 (column 0 in row MSBs).
REQ-015 SHALL implement a 3-stage pipeline: S1 registers 9 signed products (2*DATA_WIDTH bits) per channel; S2 registers their sign-extended sum (2*DATA_WIDTH+4 bits); S3 adds 2^(FRAC_BITS-1), arithmetic-shifts right FRAC_BITS, applies ReLU if relu_en, and saturates to signed DATA_WIDTH.
REQ-016 SHALL carry relu_en down the pipeline with its beat.
REQ-017 SHALL define stall = out_valid && !out_ready; while stalled every stage holds.
REQ-018 SHALL drive act_ready = ker_loaded && !stall; act_ready is 0 in ROW0..ROW2.
REQ-019 SHALL produce out_valid exactly 3 cycles after acceptance when out_ready is held high (one result per cycle sustained).
REQ-020 SHALL hold out_data and out_valid stable while stalled; out_data is unspecified when out_valid=0.
REQ-021 SHALL never drop or duplicate a beat under arbitrary out_ready toggling.
REQ-022 SHALL saturate to +2^(DATA_WIDTH-1)-1 / -2^(DATA_WIDTH-1); ReLU is applied before saturation.

Reset
REQ-023 SHALL, on rst_n low, asynchronously force FSM=ROW0, all stage-valid flags 0, out_valid=0, wt_ready=1, act_ready=0, ker_loaded=0, out_data=0.
REQ-024 SHALL discard in-flight beats and loaded weights on mid-operation reset; a full 3-row reload is required afterwards.
REQ-025 SHALL not reset weight and product data registers except through valid-flag clearing (out_data reset to 0 only).

Structure
REQ-026 SHALL place the load FSM state enum, the accumulator-width function (2*DATA_WIDTH+4) and tap/row index constants in a shared package pe_pkg.
REQ-027 SHALL implement one channel (weight rows, 9 multipliers, sum, round/ReLU/saturate) as sub-module pe_ch_mac, instantiated NUM_CH times by a generate loop; the FSM and valid/stall control live only in pe_array_mac.

Verification (NUM_CH=4, DATA_WIDTH=16, FRAC_BITS=8)
REQ-028 SHALL cover load: 3 wt beats with wt_valid gaps -> ker_loaded=1 after third beat, wt_ready=0 after, act_ready=1.
REQ-029 SHALL cover arithmetic: all weights 0x0100 (1.0), all taps 0x0080 (0.5) -> every channel out_data=0x0480 exactly 3 cycles after acceptance.
REQ-030 SHALL cover saturation/ReLU: weights 0x7FFF, taps 0x7FFF -> 0x7FFF; taps 0x8000 -> 0x8000 with relu_en=0, 0x0000 with relu_en=1.
REQ-031 SHALL cover backpressure: 10 back-to-back beats, out_ready toggling pseudo-randomly -> 10 outputs in order, data stable while stalled, act_ready=0 when stalled.
REQ-032 SHALL cover ker_clear: pulse with 2 beats in flight -> ignored, both outputs delivered; pulse when empty -> FSM ROW0, act_ready=0, wt_ready=1.
REQ-033 SHALL cover reset: rst_n low for 1 cycle with 3 beats in flight -> out_valid=0 immediately, no stale outputs, ker_loaded=0.
